icache_controller: RTL and testbench

//   Direct-mapped, read-only instruction cache between the IF-stage PC and a
//   256-bit-line backing instruction memory. Replaces the combinational

---
 rtl/icache_controller_pkg.sv | 31 +++
 rtl/icache_controller_if.sv | 34 +++
 rtl/icache_sram.sv | 40 ++++
 rtl/icache_controller.sv | 91 +++++++++
 tb/tb_icache_controller.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/icache_controller_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Address split: tag | index | word | byte.
package icache_controller_pkg;

   localparam int NUM_LINES = 16;
   localparam int LINE_W    = 256;
   localparam int ADDR_W    = 32;
   localparam int OFFSET_W  = 5;
   localparam int INDEX_W   = $clog2(NUM_LINES);
   localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;

   localparam logic [1:0] IC_IDLE = 2'd0;
   localparam logic [1:0] IC_MISS = 2'd1;
   localparam logic [1:0] IC_FILL = 2'd2;

   typedef logic [TAG_W-1:0]   tag_t;
   typedef logic [INDEX_W-1:0] idx_t;
   typedef logic [LINE_W-1:0]  line_t;

   typedef struct packed {
      tag_t       tag;
      idx_t       idx;
      logic [2:0] word;
      logic [1:0] byte_off;
   } addr_t;

   function automatic addr_t split(input logic [ADDR_W-1:0] a);
      return addr_t'(a);
   endfunction

endpackage

// File: rtl/icache_controller_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// slave = cache controller, master = CPU front end plus backing memory.
interface icache_controller_if;
   import icache_controller_pkg::*;

   logic              cpu_req_i;
   logic [ADDR_W-1:0] cpu_addr_i;
   logic              invalidate_i;
   logic [31:0]       cpu_instr_o;
   logic              cpu_stall_o;
   logic              mem_enable_o;
   logic [ADDR_W-1:0] mem_addr_o;
   line_t             mem_data_i;
   logic              mem_ack_i;
   logic [31:0]       hit_count_o;
   logic [31:0]       miss_count_o;

   modport slave (
      input  cpu_req_i, cpu_addr_i, invalidate_i,
      input  mem_data_i, mem_ack_i,
      output cpu_instr_o, cpu_stall_o,
      output mem_enable_o, mem_addr_o,
      output hit_count_o, miss_count_o
   );

   modport master (
      output cpu_req_i, cpu_addr_i, invalidate_i,
      output mem_data_i, mem_ack_i,
      input  cpu_instr_o, cpu_stall_o,
      input  mem_enable_o, mem_addr_o,
      input  hit_count_o, miss_count_o
   );

endinterface

// File: rtl/icache_sram.sv
// Valid/tag/data storage: async read by index, sync write.
// A valid-clear on the same edge as a write leaves the line invalid.
module icache_sram
   import icache_controller_pkg::*;
(
   input  logic  clk_i,
   input  logic  clr,
   input  logic  we,
   input  idx_t  widx,
   input  tag_t  wtag,
   input  line_t wline,
   input  idx_t  ridx,
   output logic  rvalid,
   output tag_t  rtag,
   output line_t rline
);

   logic [NUM_LINES-1:0] valid;
   tag_t                 tag_arr  [NUM_LINES];
   line_t                data_arr [NUM_LINES];

   always_ff @(posedge clk_i) begin
      if (clr)
         valid <= '0;
      else if (we)
         valid[widx] <= 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (we) begin
         tag_arr[widx]  <= wtag;
         data_arr[widx] <= wline;
      end
   end

   assign rvalid = valid[ridx];
   assign rtag   = tag_arr[ridx];
   assign rline  = data_arr[ridx];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped read-only I-cache: 0-cycle hits, stalls the
// front end across a single outstanding line refill.
module icache_controller
   import icache_controller_pkg::*;
(
   input  logic           clk_i,
   input  logic           rst_i,
   icache_controller_if.slave bus
);

   logic [1:0] state, state_nx;
   addr_t      req_a;
   tag_t       fill_tag;
   idx_t       fill_idx;
   logic       rd_valid;
   tag_t       rd_tag;
   line_t      rd_line;
   logic       is_idle, hit, miss, ack_fill, clr;

   assign req_a    = split(bus.cpu_addr_i);
   assign is_idle  = (state == IC_IDLE);
   assign hit      = bus.cpu_req_i & rd_valid
                   & (rd_tag == req_a.tag);
   assign miss     = is_idle & bus.cpu_req_i & ~hit;
   assign ack_fill = rst_i & (state == IC_MISS)
                   & bus.mem_ack_i;
   assign clr      = ~rst_i | bus.invalidate_i;

   // Refill targets the latched miss address, not the live PC.
   icache_sram u_sram (
      .clk_i  (clk_i),
      .clr    (clr),
      .we     (ack_fill),
      .widx   (fill_idx),
      .wtag   (fill_tag),
      .wline  (bus.mem_data_i),
      .ridx   (req_a.idx),
      .rvalid (rd_valid),
      .rtag   (rd_tag),
      .rline  (rd_line)
   );

   assign bus.mem_addr_o = {fill_tag, fill_idx, 5'b0};

   always_comb begin
      bus.cpu_instr_o = '0;
      bus.cpu_stall_o = 1'b0;
      if (rst_i) begin
         if (!is_idle)
            bus.cpu_stall_o = 1'b1;
         else if (hit)
            bus.cpu_instr_o = rd_line[32*req_a.word +: 32];
         else
            bus.cpu_stall_o = bus.cpu_req_i;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IC_IDLE: if (miss) state_nx = IC_MISS;
         IC_MISS: if (bus.mem_ack_i) state_nx = IC_FILL;
         IC_FILL: state_nx = IC_IDLE;
         default: state_nx = IC_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state            <= IC_IDLE;
         bus.mem_enable_o <= 1'b0;
         fill_tag         <= '0;
         fill_idx         <= '0;
         bus.hit_count_o  <= '0;
         bus.miss_count_o <= '0;
      end else begin
         state <= state_nx;
         if (miss) begin
            fill_tag         <= req_a.tag;
            fill_idx         <= req_a.idx;
            bus.mem_enable_o <= 1'b1;
            bus.miss_count_o <= bus.miss_count_o + 32'd1;
         end
         if (ack_fill)
            bus.mem_enable_o <= 1'b0;
         if (is_idle && hit)
            bus.hit_count_o <= bus.hit_count_o + 32'd1;
      end
   end

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller: table of IDLE lookups
// plus hand sequences for miss, conflict, invalidate and reset.
module tb_icache_controller;
   import icache_controller_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   exp_hit = 0;
   int   exp_miss = 0;

   icache_controller_if bus ();

   icache_controller dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        ack;
      logic [31:0] instr;
      logic        stall;
      int          hit;
   } vec_t;

   vec_t vt [7];

   function automatic line_t mk_line(input logic [31:0] a);
      line_t l;
      for (int w = 0; w < 8; w++) begin
         if (a == 32'h0 && w == 1)
            l[32*w +: 32] = 32'h0010_0093;
         else
            l[32*w +: 32] = 32'hA000_0000 | a | (w << 2);
      end
      return l;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_miss(input logic [31:0] a, input logic inval);
      int n;
      @(negedge clk);
      bus.cpu_req_i  = 1'b1;
      bus.cpu_addr_i = a;
      #1 chk("miss_stall", 32'(bus.cpu_stall_o), 32'd1);
      exp_miss++;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.mem_enable_o && n < 16);
      chk("miss_enable_delay", n, 1);
      chk("miss_addr", bus.mem_addr_o, a & ~32'h1F);
      chk("miss_count", bus.miss_count_o, exp_miss);
      repeat (9) @(negedge clk);
      chk("miss_hold",
          32'({bus.cpu_stall_o, bus.mem_enable_o}), 32'b11);
      bus.mem_ack_i    = 1'b1;
      bus.mem_data_i   = mk_line(a & ~32'h1F);
      bus.invalidate_i = inval;
      @(negedge clk);
      bus.mem_ack_i    = 1'b0;
      bus.invalidate_i = 1'b0;
      bus.mem_data_i   = '0;
      #1 chk("fill_state",
             32'({bus.cpu_stall_o, bus.mem_enable_o}), 32'b10);
   endtask

   task automatic hit_at(input logic [31:0] a, input logic [31:0] ins);
      @(negedge clk);
      bus.cpu_req_i  = 1'b1;
      bus.cpu_addr_i = a;
      #1 chk("hit_instr", bus.cpu_instr_o, ins);
      chk("hit_stall", 32'(bus.cpu_stall_o), 32'd0);
      exp_hit++;
      @(posedge clk);
      #1 chk("hit_count", bus.hit_count_o, exp_hit);
   endtask

   initial begin
      vt[0] = '{1'b1, 32'h00,  1'b0, 32'hA000_0000, 1'b0, 1};
      vt[1] = '{1'b1, 32'h08,  1'b0, 32'hA000_0008, 1'b0, 1};
      vt[2] = '{1'b1, 32'h1C,  1'b0, 32'hA000_001C, 1'b0, 1};
      vt[3] = '{1'b1, 32'h06,  1'b0, 32'h0010_0093, 1'b0, 1};
      vt[4] = '{1'b0, 32'h00,  1'b1, 32'h0,         1'b0, 0};
      vt[5] = '{1'b0, 32'h200, 1'b0, 32'h0,         1'b0, 0};
      vt[6] = '{1'b1, 32'h00,  1'b0, 32'hA000_0000, 1'b0, 1};

      rst              = 1'b0;
      bus.cpu_req_i    = 1'b1;
      bus.cpu_addr_i   = 32'h4;
      bus.invalidate_i = 1'b0;
      bus.mem_ack_i    = 1'b0;
      bus.mem_data_i   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 chk("rst_stall", 32'(bus.cpu_stall_o), 32'd0);
      chk("rst_instr", bus.cpu_instr_o, 32'd0);
      chk("rst_enable", 32'(bus.mem_enable_o), 32'd0);
      chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
      chk("rst_hits", bus.hit_count_o, 32'd0);
      chk("rst_misses", bus.miss_count_o, 32'd0);
      @(negedge clk);
      rst           = 1'b1;
      bus.cpu_req_i = 1'b0;

      // cold miss, then the held PC hits
      do_miss(32'h4, 1'b0);
      hit_at(32'h4, 32'h0010_0093);
      chk("cold_misses", bus.miss_count_o, 32'd1);

      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         bus.cpu_req_i  = vt[i].req;
         bus.cpu_addr_i = vt[i].addr;
         bus.mem_ack_i  = vt[i].ack;
         bus.mem_data_i = {8{32'h5555_AAAA}};
         #1 chk("vec_instr", bus.cpu_instr_o, vt[i].instr);
         chk("vec_stall", 32'(bus.cpu_stall_o), 32'(vt[i].stall));
         chk("vec_enable", 32'(bus.mem_enable_o), 32'd0);
         exp_hit += vt[i].hit;
         @(posedge clk);
         #1 chk("vec_hits", bus.hit_count_o, exp_hit);
         chk("vec_misses", bus.miss_count_o, exp_miss);
         bus.mem_ack_i  = 1'b0;
         bus.mem_data_i = '0;
      end

      // conflict on index 0
      do_miss(32'h200, 1'b0);
      hit_at(32'h200, 32'hA000_0200);
      do_miss(32'h0, 1'b0);
      hit_at(32'h0, 32'hA000_0000);
      chk("conflict_misses", bus.miss_count_o, 32'd3);

      // invalidate coincident with the refill ack
      do_miss(32'h44, 1'b1);
      do_miss(32'h44, 1'b0);
      hit_at(32'h44, 32'hA000_0044);
      chk("inval_misses", bus.miss_count_o, 32'd5);

      // reset on the 4th MISS cycle, then a stray ack
      @(negedge clk);
      bus.cpu_req_i  = 1'b1;
      bus.cpu_addr_i = 32'h80;
      #1 chk("rmiss_stall", 32'(bus.cpu_stall_o), 32'd1);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      #1 chk("rmiss_rst_stall", 32'(bus.cpu_stall_o), 32'd0);
      chk("rmiss_rst_instr", bus.cpu_instr_o, 32'd0);
      @(negedge clk);
      rst           = 1'b1;
      bus.cpu_req_i = 1'b0;
      #1 chk("rmiss_enable", 32'(bus.mem_enable_o), 32'd0);
      chk("rmiss_hits", bus.hit_count_o, 32'd0);
      chk("rmiss_misses", bus.miss_count_o, 32'd0);
      exp_hit  = 0;
      exp_miss = 0;
      repeat (5) @(negedge clk);
      bus.mem_ack_i  = 1'b1;
      bus.mem_data_i = {8{32'hDEAD_BEEF}};
      @(negedge clk);
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      #1 chk("stray_enable", 32'(bus.mem_enable_o), 32'd0);
      chk("stray_stall", 32'(bus.cpu_stall_o), 32'd0);
      do_miss(32'h0, 1'b0);
      hit_at(32'h0, 32'hA000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
